sop_pos_checker: RTL and testbench

- Response-analysis end of the 3-input SOP/POS truth-table exercise: the stimulus side drives the 8 input combinations into the SOP and POS forms of F = y | (~x & z), and this block receives the resulting (vector, FS, FP) samples.
- Checks each sample against the expected truth table, enforces ascending vector order, and applies a stall timeout.
- Reports captured minterm masks, an error count and a pass/done verdict.
- Sits on-chip alongside the function implementations so the exhaustive check runs in hardware, not only in simulation.

---
 rtl/sop_pos_checker.sv | 87 ++++++++
 tb/tb_sop_pos_checker.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sop_pos_checker.sv
// Response checker for the SOP/POS truth-table exercise. It collects the
// (vector, FS, FP) samples, compares them with EXP_MASK and reports a verdict.
module sop_pos_checker #(
  parameter logic [7:0] EXP_MASK = 8'hCE,
  parameter int         TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_vec,
  input  logic       in_fs,
  input  logic       in_fp,
  output logic [7:0] fs_mask,
  output logic [7:0] fp_mask,
  output logic [3:0] err_count,
  output logic       seq_err,
  output logic       timeout,
  output logic       done,
  output logic       pass
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t     state, nstate;
  logic [2:0] idx;
  logic [7:0] stall;
  logic       accept, last, stalled, smp_err, smp_seq;

  // A start in the same cycle discards the presented sample.
  assign accept  = in_valid && in_ready && !start;
  assign last    = accept && (idx == 3'd7);
  assign stalled = (state == COLLECT) && !start && !accept && (stall == 8'(TIMEOUT - 1));
  assign smp_err = (in_fs != EXP_MASK[in_vec]) || (in_fp != EXP_MASK[in_vec]);
  assign smp_seq = (in_vec != idx);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = COLLECT;
      COLLECT: if (start) nstate = COLLECT;
               else if (last || stalled) nstate = DONE;
      DONE:    if (start) nstate = COLLECT;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == COLLECT);
    done     = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      fs_mask   <= '0;
      fp_mask   <= '0;
      err_count <= '0;
      seq_err   <= 1'b0;
      timeout   <= 1'b0;
      pass      <= 1'b0;
      idx       <= '0;
      stall     <= '0;
    end else if (accept) begin
      fs_mask[in_vec] <= in_fs;
      fp_mask[in_vec] <= in_fp;
      err_count       <= err_count + 4'(smp_err);
      seq_err         <= seq_err | smp_seq;
      idx             <= idx + 3'd1;
      stall           <= '0;
      // Verdict must include the eighth sample, so fold it in combinationally.
      if (last)
        pass <= ((err_count + 4'(smp_err)) == 4'd0) && !(seq_err | smp_seq);
    end else if (stalled) begin
      timeout <= 1'b1;
      pass    <= 1'b0;
    end else if (state == COLLECT) begin
      stall <= stall + 8'd1;
    end
  end

endmodule

// File: tb/tb_sop_pos_checker.sv
// Scoreboard bench for sop_pos_checker: the driver keeps a sample-list model of
// each run and queues the expected verdict; a monitor checks it when done rises.
module tb_sop_pos_checker;
  localparam logic [7:0] EXP = 8'hCE;
  localparam int         TO  = 16;
  localparam logic [23:0] ORD  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [23:0] ORD2 = {3'd7, 3'd6, 3'd5, 3'd4, 3'd2, 3'd3, 3'd1, 3'd0};

  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic       in_fs = 1'b0, in_fp = 1'b0;
  logic [2:0] in_vec = 3'd0;
  logic       in_ready, seq_err, timeout, done, pass;
  logic [7:0] fs_mask, fp_mask;
  logic [3:0] err_count;

  sop_pos_checker #(.EXP_MASK(EXP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .in_fs(in_fs), .in_fp(in_fp), .fs_mask(fs_mask), .fp_mask(fp_mask),
    .err_count(err_count), .seq_err(seq_err), .timeout(timeout), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] fs; logic [7:0] fp; int err; bit seq; bit to; bit pass; int at; } exp_t;
  typedef struct { logic [2:0] v; bit fs; bit fp; } smp_t;

  exp_t       sbq[$];
  smp_t       run[$];
  bit         active = 1'b0;
  int         idle = 0;
  int         n_chk = 0, n_pass = 0;
  logic [7:0] expm = EXP;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Expected verdict straight from the list of accepted samples.
  function automatic void finish_run(input bit to);
    exp_t e;
    e.fs = '0; e.fp = '0; e.err = 0; e.seq = 1'b0;
    foreach (run[k]) begin
      e.fs[run[k].v] = run[k].fs;
      e.fp[run[k].v] = run[k].fp;
      if (run[k].fs != expm[run[k].v] || run[k].fp != expm[run[k].v]) e.err++;
      if (int'(run[k].v) != k) e.seq = 1'b1;
    end
    e.to   = to;
    e.pass = !to && (e.err == 0) && !e.seq;
    e.at   = cyc + 1;
    sbq.push_back(e);
    active = 1'b0;
  endfunction

  task automatic cycle(input bit v, input logic [2:0] vec, input bit fs, input bit fp, input bit st);
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(active));
    start = st; in_valid = v; in_vec = vec; in_fs = fs; in_fp = fp;
    if (st) begin
      active = 1'b1; run.delete(); idle = 0;
    end else if (active) begin
      if (v) begin
        run.push_back('{vec, fs, fp});
        idle = 0;
        if (run.size() == 8) finish_run(1'b0);
      end else if (idle == TO - 1) finish_run(1'b1);
      else idle++;
    end
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [2:0] v, input bit ffs, input bit ffp);
    cycle(1'b1, v, expm[v] ^ ffs, expm[v] ^ ffp, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    active = 1'b0; run.delete(); idle = 0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_outputs", {fs_mask, fp_mask, err_count, seq_err, timeout, done, pass, in_ready}, 32'd0);
  endtask

  task automatic run_full(input logic [23:0] ord, input logic [7:0] ffs, input logic [7:0] ffp, input bit gap);
    logic [2:0] v;
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      v = ord[3*k +: 3];
      send(v, ffs[v], ffp[v]);
      if (gap) idle_n(1);
    end
    idle_n(2);
  endtask

  exp_t e;
  logic done_q = 1'b0;
  always @(negedge clk) begin
    if (done === 1'b1 && done_q !== 1'b1) begin
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got done=1 want no pending verdict (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.at));
        chk("fs_mask", 32'(fs_mask), 32'(e.fs));
        chk("fp_mask", 32'(fp_mask), 32'(e.fp));
        chk("err_count", 32'(err_count), 32'(e.err));
        chk("seq_err", 32'(seq_err), 32'(e.seq));
        chk("timeout", 32'(timeout), 32'(e.to));
        chk("pass", 32'(pass), 32'(e.pass));
      end
    end
    done_q <= done;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, n, rst_at;
    logic [2:0] v;
    do_reset();

    // Samples offered in IDLE must be ignored.
    for (int i = 0; i < 4; i++) cycle(1'b1, 3'(i), 1'b1, 1'b1, 1'b0);
    idle_n(1);
    chk("idle_fs_mask", 32'(fs_mask), 32'd0);

    run_full(ORD, 8'h00, 8'h00, 1'b0);   // correct
    run_full(ORD, 8'h00, 8'h10, 1'b0);   // faulty POS at vector 4
    run_full(ORD2, 8'h00, 8'h00, 1'b0);  // order error
    run_full(ORD, 8'h00, 8'h00, 1'b1);   // gapped handshake

    // Timeout after three samples.
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) send(3'(k), 1'b0, 1'b0);
    idle_n(TO + 2);

    // Restart mid-run, then a full run.
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) send(3'(k), 1'b0, 1'b0);
    run_full(ORD, 8'h00, 8'h00, 1'b0);

    // Reset mid-run.
    cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) send(3'(k), 1'b0, 1'b0);
    do_reset();

    for (int r = 0; r < 40; r++) begin
      mode   = $urandom_range(0, 9);
      n      = (mode == 0) ? $urandom_range(0, 7) : 8;
      rst_at = (mode == 2) ? 4 : 99;
      cycle($urandom_range(0, 1) == 1, 3'($urandom), 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < n; k++) begin
        if (k == rst_at) begin do_reset(); break; end
        if (mode == 1 && k == 3) cycle(1'b1, 3'd3, 1'b0, 1'b0, 1'b1);
        while ($urandom_range(0, 2) == 0) idle_n(1);
        v = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'(k);
        send(v, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      end
      for (int g = 0; g < 40 && active; g++) idle_n(1);
      for (int g = 0; g < 2; g++) cycle(1'b1, 3'($urandom), 1'b1, 1'b1, 1'b0);
    end

    idle_n(3);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
